// File: rtl/rr_wide_mux.sv
// N-channel, WIDTH-bit selector with a single registered output stage and
// valid/ready handshakes; fixed-select or round-robin channel choice.
module rr_wide_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic             load;
  logic [NCH-1:0]   fx_grant;
  logic [NCH-1:0]   hi_req;
  logic [NCH-1:0]   rr_req;
  logic [NCH-1:0]   rr_grant;
  logic [NCH-1:0]   grant;
  logic             any_grant;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  // The output register can take a new word whenever it is empty or is
  // being drained in this same cycle.
  assign load = ~out_valid | out_ready;

  // Fixed select: an out-of-range sel matches no channel, so nothing is granted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    fx_grant = '0;
    for (int i = 0; i < NCH; i++) begin
      fx_grant[i] = in_valid[i] && (sel == SELW'(i));
    end
  end

  // Round-robin: prefer requesters at or above ptr; if none, wrap to the
  // lowest requester overall. Lowest set bit of the chosen set wins.
  always_comb begin
    hi_req = '0;
    for (int i = 0; i < NCH; i++) begin
      hi_req[i] = in_valid[i] && (SELW'(i) >= ptr);
    end
    rr_req   = (|hi_req) ? hi_req : in_valid;
    rr_grant = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rr_req[i]) begin
        rr_grant    = '0;
        rr_grant[i] = 1'b1;
      end
    end
  end

  assign grant     = mode ? rr_grant : fx_grant;
  assign any_grant = |grant;

  // grant is one-hot or zero, so an AND-OR select and index encode suffice.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        gnt_idx = SELW'(i);
      end
      gnt_data = gnt_data | ({WIDTH{grant[i]}} & in_data[i*WIDTH +: WIDTH]);
    end
  end

  // Reset also masks in_ready so producers never see a handshake that the
  // register would discard.
  assign in_ready = {NCH{load & ~rst}} & grant;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any_grant) begin
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        out_valid <= 1'b1;
        if (mode) begin
          ptr <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_wide_mux.sv
// Directed bench for rr_wide_mux (WIDTH=32, NCH=4, SELW=3) with
// hand-computed expectations checked by immediate assertions.
module tb_rr_wide_mux;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 3;

  localparam logic [31:0] D0 = 32'h0C0C0C00;
  localparam logic [31:0] D1 = 32'h55555555;
  localparam logic [31:0] D2 = 32'hAAAAAAAA;
  localparam logic [31:0] D3 = 32'h33333333;

  logic                 clk;
  logic                 rst;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  rr_wide_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [2:0] ch,
                           input logic [31:0] data);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
    check({tag, ".out_ch"},    32'(out_ch),    32'(ch));
    check({tag, ".out_data"},  out_data,       data);
  endtask

  function automatic logic [31:0] dval(input int ch);
    case (ch)
      0:       return D0;
      1:       return D1;
      2:       return D2;
      default: return D3;
    endcase
  endfunction

  initial begin
    int rr_seq [6];
    int alt_seq[4];
    rr_seq  = '{0, 1, 2, 3, 0, 1};
    alt_seq = '{3, 1, 3, 1};

    rst       = 1'b1;
    mode      = 1'b1;
    sel       = '0;
    in_data   = {D3, D2, D1, D0};
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Reset held two cycles with every channel valid.
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rst.in_ready", 32'(in_ready), 32'h0);
      tick();
      check_out("rst", 1'b0, 3'd0, 32'h0);
    end

    // Round-robin from ptr=0, all channels valid: 0,1,2,3,0,1.
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr.in_ready", 32'(in_ready), 32'(1 << rr_seq[k]));
      tick();
      check_out("rr", 1'b1, 3'(rr_seq[k]), dval(rr_seq[k]));
    end

    // Only ch1 and ch3 valid, ptr=2: 3,1,3,1.
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("alt.in_ready", 32'(in_ready), 32'(1 << alt_seq[k]));
      tick();
      check_out("alt", 1'b1, 3'(alt_seq[k]), dval(alt_seq[k]));
    end

    // Back-pressure: ch1 word held for 3 cycles, no in_ready.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp.in_ready", 32'(in_ready), 32'h0);
      tick();
      check_out("bp.hold", 1'b1, 3'd1, D1);
    end

    // Release: same-cycle reload of ch3 (ptr=2), no bubble.
    out_ready = 1'b1;
    #1;
    check("bp.release.in_ready", 32'(in_ready), 32'b1000);
    tick();
    check_out("bp.reload", 1'b1, 3'd3, D3);

    // Drive ptr to 3 by accepting ch2.
    in_valid = 4'b0100;
    #1;
    check("ptr3.in_ready", 32'(in_ready), 32'b0100);
    tick();
    check_out("ptr3", 1'b1, 3'd2, D2);

    // Wrap-around: ptr=3, only ch0 valid -> ch0, ptr becomes 1.
    in_valid = 4'b0001;
    #1;
    check("wrap.in_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("wrap", 1'b1, 3'd0, D0);
    in_valid = 4'b1111;
    #1;
    check("wrap.ptr1", 32'(in_ready), 32'b0010);

    // Mode 0, sel=5 is out of range: no grant, output drains.
    mode = 1'b0;
    sel  = 3'd5;
    #1;
    check("oor.in_ready", 32'(in_ready), 32'h0);
    tick();
    check("oor.out_valid", 32'(out_valid), 32'h0);
    tick();
    check("oor.stay", 32'(out_valid), 32'h0);

    // Mode 0, sel=2, empty register accepts even with out_ready=0.
    sel       = 3'd2;
    out_ready = 1'b0;
    #1;
    check("m0.empty.in_ready", 32'(in_ready), 32'b0100);
    tick();
    check_out("m0.first", 1'b1, 3'd2, D2);
    #1;
    check("m0.held.in_ready", 32'(in_ready), 32'h0);
    tick();
    check_out("m0.held", 1'b1, 3'd2, D2);

    // Mode 0 passthrough with out_ready=1, with ch1 distinct from ch2.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("m0.in_ready", 32'(in_ready), 32'b0100);
      tick();
      check_out("m0.pass", 1'b1, 3'd2, 32'hAAAAAAAA);
    end

    // Mode 0 transfers leave ptr at 1.
    mode = 1'b1;
    #1;
    check("m0.ptr_hold", 32'(in_ready), 32'b0010);

    // Reset mid-operation with a transfer pending.
    rst = 1'b1;
    #1;
    check("midrst.in_ready", 32'(in_ready), 32'h0);
    tick();
    check_out("midrst", 1'b0, 3'd0, 32'h0);
    rst = 1'b0;
    #1;
    check("midrst.ptr0", 32'(in_ready), 32'b0001);
    tick();
    check_out("midrst.after", 1'b1, 3'd0, D0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
